// File: rtl/step_btn_debounce_if.sv
// Button-side signal bundle for step_btn_debounce: raw button in, clean level,
// edge strobes and press counter out.
interface step_btn_debounce_if;
  logic       BTN;
  logic       BTN_Out;
  logic       btn_rise;
  logic       btn_fall;
  logic [7:0] press_cnt;

  // Consumer / stimulus side: drives the raw button, observes the results.
  modport master (
    output BTN,
    input  BTN_Out,
    input  btn_rise,
    input  btn_fall,
    input  press_cnt
  );

  // Debouncer side.
  modport slave (
    input  BTN,
    output BTN_Out,
    output btn_rise,
    output btn_fall,
    output press_cnt
  );
endinterface

// File: rtl/step_btn_debounce.sv
// Single-step button conditioner: 2-flop synchroniser, stability counter and a
// 4-state FSM producing a registered debounced level, edge strobes and a press count.
module step_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int CNT_WIDTH       = 21
) (
  input logic                 clk_100MHz,
  input logic                 rst,
  step_btn_debounce_if.slave  bus
);

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  // The sample that enters a WAIT state is the first stable one, so the level
  // is accepted when the counter has seen DEBOUNCE_CYCLES-1 further samples.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 2);

  logic                 s0, s1;
  logic [1:0]           state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 out_q, out_nxt;
  logic                 rise_q, rise_nxt;
  logic                 fall_q, fall_nxt;
  logic [7:0]           press_q, press_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse s0/s1 into a single stage.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= bus.BTN;
      s1 <= s0;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    out_nxt   = out_q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    press_nxt = press_q;

    case (state)
      RELEASED: begin
        out_nxt = 1'b0;
        if (s1) state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!s1) begin
          state_nxt = RELEASED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          out_nxt   = 1'b1;
          rise_nxt  = 1'b1;
          press_nxt = press_q + 8'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        out_nxt = 1'b1;
        if (!s1) state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (s1) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RELEASED;
          out_nxt   = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RELEASED;
        out_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state   <= RELEASED;
      cnt     <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      press_q <= 8'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      out_q   <= out_nxt;
      rise_q  <= rise_nxt;
      fall_q  <= fall_nxt;
      press_q <= press_nxt;
    end
  end

  assign bus.BTN_Out   = out_q;
  assign bus.btn_rise  = rise_q;
  assign bus.btn_fall  = fall_q;
  assign bus.press_cnt = press_q;

endmodule

// File: tb/tb_step_btn_debounce.sv
// Directed bench for step_btn_debounce with DEBOUNCE_CYCLES=8: latency, bounce
// rejection, glitch rejection, press counter wrap and asynchronous reset.
module tb_step_btn_debounce;

  logic clk_100MHz = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;
  int   overlap_cnt = 0;
  int   r0, f0;

  step_btn_debounce_if bif ();

  step_btn_debounce #(
    .DEBOUNCE_CYCLES (8),
    .CNT_WIDTH       (4)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .bus        (bif)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Strobe tally, sampled 1 ns after each rising edge.
  always @(posedge clk_100MHz) begin
    #1;
    if (bif.btn_rise) rise_cnt++;
    if (bif.btn_fall) fall_cnt++;
    if (bif.btn_rise && bif.btn_fall) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on falling edges only.
  task automatic step(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    bif.BTN = 1'b0;
    step(3);
    check("reset_out",   32'(bif.BTN_Out),   32'd0);
    check("reset_rise",  32'(bif.btn_rise),  32'd0);
    check("reset_fall",  32'(bif.btn_fall),  32'd0);
    check("reset_press", 32'(bif.press_cnt), 32'd0);

    // Clean press: level appears on edge 10 after release.
    rst     = 1'b0;
    bif.BTN = 1'b1;
    step(9);
    check("clean_edge9_out",   32'(bif.BTN_Out),   32'd0);
    step(1);
    check("clean_edge10_out",  32'(bif.BTN_Out),   32'd1);
    check("clean_edge10_rise", 32'(bif.btn_rise),  32'd1);
    step(1);
    check("clean_edge11_rise", 32'(bif.btn_rise),  32'd0);
    check("clean_press",       32'(bif.press_cnt), 32'd1);
    bif.BTN = 1'b0;
    step(12);
    check("clean_released",    32'(bif.BTN_Out),   32'd0);

    // Bouncy press: 1,0,1,0 in 3-cycle segments, then held.
    do_reset();
    r0 = rise_cnt;
    bif.BTN = 1'b1; step(3);
    bif.BTN = 1'b0; step(3);
    bif.BTN = 1'b1; step(3);
    bif.BTN = 1'b0; step(3);
    bif.BTN = 1'b1;
    check("bounce_no_rise",     32'(rise_cnt - r0), 32'd0);
    step(9);
    check("bounce_edge9_out",   32'(bif.BTN_Out),   32'd0);
    step(1);
    check("bounce_edge10_out",  32'(bif.BTN_Out),   32'd1);
    check("bounce_edge10_rise", 32'(bif.btn_rise),  32'd1);
    step(1);
    check("bounce_press",       32'(bif.press_cnt), 32'd1);
    check("bounce_one_rise",    32'(rise_cnt - r0), 32'd1);
    step(3);

    // Bouncy release: low 3, high 2, low 3, high 2, then held low.
    f0 = fall_cnt;
    bif.BTN = 1'b0; step(3);
    bif.BTN = 1'b1; step(2);
    bif.BTN = 1'b0; step(3);
    bif.BTN = 1'b1; step(2);
    bif.BTN = 1'b0;
    check("rel_glitch_out",     32'(bif.BTN_Out),   32'd1);
    step(9);
    check("rel_edge9_out",      32'(bif.BTN_Out),   32'd1);
    step(1);
    check("rel_edge10_out",     32'(bif.BTN_Out),   32'd0);
    check("rel_edge10_fall",    32'(bif.btn_fall),  32'd1);
    step(1);
    check("rel_edge11_fall",    32'(bif.btn_fall),  32'd0);
    check("rel_one_fall",       32'(fall_cnt - f0), 32'd1);
    check("rel_press",          32'(bif.press_cnt), 32'd1);

    // Glitch of 7 stable samples is one short of acceptance.
    do_reset();
    r0 = rise_cnt;
    f0 = fall_cnt;
    bif.BTN = 1'b1; step(7);
    bif.BTN = 1'b0; step(14);
    check("glitch_out",   32'(bif.BTN_Out),   32'd0);
    check("glitch_rise",  32'(rise_cnt - r0), 32'd0);
    check("glitch_fall",  32'(fall_cnt - f0), 32'd0);
    check("glitch_press", 32'(bif.press_cnt), 32'd0);

    // 256 clean press/release pairs wrap press_cnt back to 0.
    do_reset();
    r0 = rise_cnt;
    f0 = fall_cnt;
    for (int i = 0; i < 256; i++) begin
      bif.BTN = 1'b1;
      step(12);
      if (i == 254) check("wrap_press_255", 32'(bif.press_cnt), 32'd255);
      bif.BTN = 1'b0;
      step(12);
    end
    check("wrap_press_0", 32'(bif.press_cnt), 32'd0);
    check("wrap_rises",   32'(rise_cnt - r0), 32'd256);
    check("wrap_falls",   32'(fall_cnt - f0), 32'd256);

    // Asynchronous reset while held pressed, then re-qualification.
    bif.BTN = 1'b1;
    step(12);
    check("midrst_pre_out",   32'(bif.BTN_Out),   32'd1);
    check("midrst_pre_press", 32'(bif.press_cnt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_async_out",   32'(bif.BTN_Out),   32'd0);
    check("midrst_async_press", 32'(bif.press_cnt), 32'd0);
    check("midrst_async_rise",  32'(bif.btn_rise),  32'd0);
    check("midrst_async_fall",  32'(bif.btn_fall),  32'd0);
    step(2);
    rst = 1'b0;
    step(9);
    check("midrst_edge9_out",   32'(bif.BTN_Out),   32'd0);
    step(1);
    check("midrst_edge10_out",  32'(bif.BTN_Out),   32'd1);
    check("midrst_edge10_rise", 32'(bif.btn_rise),  32'd1);
    step(1);
    check("midrst_press",       32'(bif.press_cnt), 32'd1);

    check("no_rise_fall_overlap", 32'(overlap_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
